// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and constants for the SDRAM video/CPU burst arbiter
//
// Purpose : state encoding, client ids, bus widths and the latched-command
//           record shared by the arbiter, its beat counter and its interface.
// Ports   : none (package).
package sdram_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT_V = 2'd1;
    localparam logic [1:0] ST_GRANT_C = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_GRANT_V = ST_GRANT_V,
        S_GRANT_C = ST_GRANT_C,
        S_RELEASE = ST_RELEASE
    } arb_state_t;

    localparam logic CLI_V = 1'b0;
    localparam logic CLI_C = 1'b1;

    // Command held for the whole burst once a client is granted.
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic              we;
        logic [LEN_W-1:0]  burst_len;
    } arb_cmd_t;

    function automatic arb_cmd_t select_cmd(input logic cli, input arb_cmd_t cmd_v,
                                            input arb_cmd_t cmd_c);
        return (cli == CLI_V) ? cmd_v : cmd_c;
    endfunction

endpackage

// File: rtl/sdram_video_arbiter_if.sv
// rtl/sdram_video_arbiter_if.sv - client and controller bus bundle for the burst arbiter
//
// Purpose : groups the video client, CPU client and SDRAM controller signals.
// Modports: master - the arbiter (drives strobes to clients, command to controller)
//           slave  - the environment (clients and controller)
// Signals : v_*  video client (read only)
//           c_*  CPU client (read/write)
//           m_*  SDRAM burst controller port
//           arb_err  one-cycle watchdog abort pulse
interface sdram_video_arbiter_if;
    import sdram_arb_pkg::*;

    logic [ADDR_W-1:0] v_address;
    logic              v_req;
    logic [LEN_W-1:0]  v_burst_len;
    logic [DATA_W-1:0] v_read_data;
    logic              v_data_available;

    logic [ADDR_W-1:0] c_address;
    logic              c_req;
    logic              c_we;
    logic [LEN_W-1:0]  c_burst_len;
    logic [DATA_W-1:0] c_write_data;
    logic [DATA_W-1:0] c_read_data;
    logic              c_data_available;
    logic              c_wdata_ack;

    logic [ADDR_W-1:0] m_address;
    logic              m_req;
    logic              m_we;
    logic [LEN_W-1:0]  m_burst_len;
    logic [DATA_W-1:0] m_write_data;
    logic [DATA_W-1:0] m_read_data;
    logic              m_data_valid;
    logic              m_wdata_ack;

    logic              arb_err;

    modport master (
        input  v_address, v_req, v_burst_len,
        output v_read_data, v_data_available,
        input  c_address, c_req, c_we, c_burst_len, c_write_data,
        output c_read_data, c_data_available, c_wdata_ack,
        output m_address, m_req, m_we, m_burst_len, m_write_data,
        input  m_read_data, m_data_valid, m_wdata_ack,
        output arb_err
    );

    modport slave (
        output v_address, v_req, v_burst_len,
        input  v_read_data, v_data_available,
        output c_address, c_req, c_we, c_burst_len, c_write_data,
        input  c_read_data, c_data_available, c_wdata_ack,
        input  m_address, m_req, m_we, m_burst_len, m_write_data,
        output m_read_data, m_data_valid, m_wdata_ack,
        input  arb_err
    );

endinterface

// File: rtl/sdram_arb_beat_counter.sv
// rtl/sdram_arb_beat_counter.sv - burst beat counter and no-beat watchdog
//
// Purpose : counts beats of the granted burst and flags the last one; with
//           ARB_TIMEOUT_EN defined also runs a watchdog that fires when a
//           grant sees no beat for TIMEOUT cycles.
// Ports   : clk, reset      clock, synchronous active-low reset
//           i_load         clear counter and watchdog (arbiter in IDLE)
//           i_beat         beat strobe, already gated to the active grant
//           i_len          latched burst length (beats minus 1)
//           o_last         this beat completes the burst
//           o_timeout      watchdog expiry (0 when ARB_TIMEOUT_EN undefined)
// Macro   : ARB_TIMEOUT_EN
module sdram_arb_beat_counter
    import sdram_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_beat,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_last,
    output logic             o_timeout
);

    logic [LEN_W-1:0] r_cnt;

    assign o_last = i_beat & (r_cnt == i_len);

    always_ff @(posedge clk) begin
        if (!reset || i_load) begin
            r_cnt <= '0;
        end else if (i_beat) begin
            r_cnt <= o_last ? '0 : r_cnt + 1'b1;
        end else if (o_timeout) begin
            r_cnt <= '0;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [LEN_W-1:0] r_wdog;

    // Fires in the cycle the watchdog reaches TIMEOUT-1 so the abort lands
    // on the TIMEOUT-th edge after grant entry.
    assign o_timeout = ~i_beat & (r_wdog == LEN_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset || i_load) begin
            r_wdog <= '0;
        end else if (i_beat || o_timeout) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    assign o_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT == 0);
`endif

endmodule

// File: rtl/sdram_video_arbiter.sv
// rtl/sdram_video_arbiter.sv - two-client SDRAM burst arbiter, video priority with CPU anti-starvation
//
// Purpose : grants the single SDRAM burst port to the video scan-out engine or
//           the CPU for a whole burst, latches that client's command and routes
//           beat data/strobes to the granted client only.
// Ports   : clk            system clock
//           reset          synchronous, active-low
//           bus            sdram_video_arbiter_if.master (video, CPU, controller, arb_err)
// Params  : MAX_V_RUN      consecutive video grants allowed while the CPU waits
//           TIMEOUT        no-beat cycles before abort (ARB_TIMEOUT_EN only)
// Macro   : ARB_TIMEOUT_EN enables the grant watchdog; undefined ties arb_err to 0
module sdram_video_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int MAX_V_RUN = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    sdram_video_arbiter_if.master bus
);

    localparam int RUN_W = $clog2(MAX_V_RUN + 1);

    arb_state_t       r_state;
    arb_cmd_t         r_cmd;
    logic             r_m_req;
    logic             r_arb_err;
    logic [RUN_W-1:0] r_v_run;

    arb_cmd_t w_cmd_v;
    arb_cmd_t w_cmd_c;
    logic     w_in_v;
    logic     w_in_c;
    logic     w_beat;
    logic     w_last;
    logic     w_timeout;
    logic     w_c_forced;

    assign w_cmd_v = '{address: bus.v_address, we: 1'b0, burst_len: bus.v_burst_len};
    assign w_cmd_c = '{address: bus.c_address, we: bus.c_we, burst_len: bus.c_burst_len};

    assign w_in_v = (r_state == S_GRANT_V);
    assign w_in_c = (r_state == S_GRANT_C);

    // Writes advance on the controller's data-consumed ack, reads on data valid.
    assign w_beat = (w_in_v & bus.m_data_valid)
                  | (w_in_c & (r_cmd.we ? bus.m_wdata_ack : bus.m_data_valid));

    assign w_c_forced = bus.c_req & (r_v_run == RUN_W'(MAX_V_RUN));

    sdram_arb_beat_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_beat_counter (
        .clk       (clk),
        .reset     (reset),
        .i_load    (r_state == S_IDLE),
        .i_beat    (w_beat),
        .i_len     (r_cmd.burst_len),
        .o_last    (w_last),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cmd     <= '0;
            r_m_req   <= 1'b0;
            r_arb_err <= 1'b0;
            r_v_run   <= '0;
        end else begin
            r_arb_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_c_forced) begin
                        r_state <= S_GRANT_C;
                        r_cmd   <= select_cmd(CLI_C, w_cmd_v, w_cmd_c);
                        r_m_req <= 1'b1;
                        r_v_run <= '0;
                    end else if (bus.v_req) begin
                        r_state <= S_GRANT_V;
                        r_cmd   <= select_cmd(CLI_V, w_cmd_v, w_cmd_c);
                        r_m_req <= 1'b1;
                        // Not forced, so r_v_run < MAX_V_RUN here: increment cannot overflow.
                        r_v_run <= bus.c_req ? r_v_run + 1'b1 : '0;
                    end else if (bus.c_req) begin
                        r_state <= S_GRANT_C;
                        r_cmd   <= select_cmd(CLI_C, w_cmd_v, w_cmd_c);
                        r_m_req <= 1'b1;
                        r_v_run <= '0;
                    end else begin
                        r_v_run <= '0;
                    end
                end
                S_GRANT_V, S_GRANT_C: begin
                    // The controller cannot abort, so a client dropping its
                    // request mid-burst does not end the grant.
                    if (w_last) begin
                        r_state <= S_RELEASE;
                        r_m_req <= 1'b0;
                    end else if (w_timeout) begin
                        r_state   <= S_RELEASE;
                        r_m_req   <= 1'b0;
                        r_arb_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.m_address    = r_cmd.address;
    assign bus.m_we         = r_cmd.we;
    assign bus.m_burst_len  = r_cmd.burst_len;
    assign bus.m_req        = r_m_req;
    assign bus.m_write_data = bus.c_write_data;
    assign bus.arb_err      = r_arb_err;

    assign bus.v_read_data      = bus.m_read_data;
    assign bus.c_read_data      = bus.m_read_data;
    assign bus.v_data_available = bus.m_data_valid & w_in_v;
    assign bus.c_data_available = bus.m_data_valid & w_in_c;
    assign bus.c_wdata_ack      = bus.m_wdata_ack & w_in_c;

endmodule

// File: tb/tb_sdram_video_arbiter.sv
// tb/tb_sdram_video_arbiter.sv - scoreboard bench for the SDRAM video/CPU burst arbiter
module tb_sdram_video_arbiter;
    import sdram_arb_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    sdram_video_arbiter_if bus ();

    sdram_video_arbiter #(
        .MAX_V_RUN (4),
        .TIMEOUT   (255)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    arb_cmd_t    gq[$];
    logic [15:0] vq[$];
    logic [15:0] cq[$];
    logic [15:0] wq[$];

    arb_cmd_t    mon_cmd;
    logic        prev_req = 1'b0;

    localparam int DST_NONE = 0;
    localparam int DST_V    = 1;
    localparam int DST_C    = 2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic extra(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event, expected none", name);
    endtask

    // Monitor: pops expected grants/beats whenever the DUT presents one.
    always @(negedge clk) begin
        if (bus.m_req && !prev_req) begin
            if (gq.size() == 0) begin
                extra("grant");
            end else begin
                mon_cmd = gq.pop_front();
                check("grant_addr", bus.m_address, mon_cmd.address);
                check("grant_we", bus.m_we, mon_cmd.we);
                check("grant_len", bus.m_burst_len, mon_cmd.burst_len);
            end
        end
        prev_req <= bus.m_req;
        if (bus.v_data_available) begin
            if (vq.size() == 0) extra("v_beat");
            else check("v_data", bus.v_read_data, vq.pop_front());
        end
        if (bus.c_data_available) begin
            if (cq.size() == 0) extra("c_beat");
            else check("c_data", bus.c_read_data, cq.pop_front());
        end
        if (bus.c_wdata_ack) begin
            if (wq.size() == 0) extra("c_wack");
            else begin
                check("m_wdata", bus.m_write_data, wq.pop_front());
                check("wack_we", bus.m_we, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.m_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, bus.m_req, 1);
    endtask

    task automatic rd_beat(input logic [15:0] d, input int dst);
        if (dst == DST_V) vq.push_back(d);
        if (dst == DST_C) cq.push_back(d);
        bus.m_read_data  = d;
        bus.m_data_valid = 1'b1;
        tick();
        bus.m_data_valid = 1'b0;
    endtask

    task automatic wr_beat(input logic [15:0] d);
        wq.push_back(d);
        bus.c_write_data = d;
        bus.m_wdata_ack  = 1'b1;
        tick();
        bus.m_wdata_ack  = 1'b0;
    endtask

    task automatic push_grant(input logic [31:0] a, input logic we, input logic [7:0] len);
        arb_cmd_t e;
        e.address   = a;
        e.we        = we;
        e.burst_len = len;
        gq.push_back(e);
    endtask

    initial begin
        int err_seen;
        int n;
        bus.v_address = '0; bus.v_req = 1'b0; bus.v_burst_len = '0;
        bus.c_address = '0; bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_burst_len = '0;
        bus.c_write_data = '0;
        bus.m_read_data = '0; bus.m_data_valid = 1'b0; bus.m_wdata_ack = 1'b0;
        repeat (3) tick();
        reset = 1'b1;

        // Reset state, and beats arriving in IDLE are not routed.
        bus.m_data_valid = 1'b1;
        bus.m_read_data  = 16'hDEAD;
        @(negedge clk);
        check("rst_m_req", bus.m_req, 0);
        check("rst_m_we", bus.m_we, 0);
        check("rst_m_address", bus.m_address, 0);
        check("rst_m_len", bus.m_burst_len, 0);
        check("rst_arb_err", bus.arb_err, 0);
        check("idle_v_strobe", bus.v_data_available, 0);
        check("idle_c_strobe", bus.c_data_available, 0);
        tick();
        bus.m_data_valid = 1'b0;

        // 1: 32-beat video burst.
        push_grant(32'hC00404, 1'b0, 8'd31);
        bus.v_address = 32'hC00404; bus.v_burst_len = 8'd31; bus.v_req = 1'b1;
        wait_grant("t1_grant");
        bus.v_req = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) rd_beat(16'h1000 + 16'(i), DST_V);
        @(negedge clk);
        check("t1_mreq_low_after_last", bus.m_req, 0);
        check("t1_v_beats_32", vq.size(), 0);
        repeat (3) tick();

        // 2: simultaneous requests, video first, CPU 2 cycles after last beat.
        push_grant(32'h100, 1'b0, 8'd0);
        push_grant(32'h2000, 1'b0, 8'd1);
        bus.v_address = 32'h100; bus.v_burst_len = 8'd0;
        bus.c_address = 32'h2000; bus.c_burst_len = 8'd1; bus.c_we = 1'b0;
        bus.v_req = 1'b1; bus.c_req = 1'b1;
        wait_grant("t2_grant_v");
        bus.v_req = 1'b0;
        tick();
        rd_beat(16'h2222, DST_V);
        @(negedge clk); check("t2_gap_release", bus.m_req, 0);
        @(negedge clk); check("t2_gap_idle", bus.m_req, 0);
        @(negedge clk); check("t2_grant_c_at_2", bus.m_req, 1);
        bus.c_req = 1'b0;
        tick();
        rd_beat(16'h2A00, DST_C);
        rd_beat(16'h2A01, DST_C);
        repeat (3) tick();

        // 3: video held, CPU waiting: V V V V C V V V V C.
        bus.v_address = 32'h300; bus.v_burst_len = 8'd0;
        bus.c_address = 32'h400; bus.c_burst_len = 8'd0; bus.c_we = 1'b0;
        bus.v_req = 1'b1; bus.c_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) push_grant(32'h400, 1'b0, 8'd0);
            else push_grant(32'h300, 1'b0, 8'd0);
            wait_grant("t3_grant");
            if (i == 9) begin
                bus.v_req = 1'b0;
                bus.c_req = 1'b0;
            end
            tick();
            rd_beat(16'h3000 + 16'(i), (i == 4 || i == 9) ? DST_C : DST_V);
        end
        repeat (3) tick();

        // 4: CPU write, 4 beats on non-consecutive acks.
        push_grant(32'h5000, 1'b1, 8'd3);
        bus.c_address = 32'h5000; bus.c_we = 1'b1; bus.c_burst_len = 8'd3; bus.c_req = 1'b1;
        wait_grant("t4_grant");
        bus.c_req = 1'b0;
        tick();
        wr_beat(16'hA000);
        tick();
        wr_beat(16'hA001);
        tick();
        tick();
        wr_beat(16'hA002);
        @(negedge clk);
        check("t4_hold_after_3", bus.m_req, 1);
        check("t4_we_held", bus.m_we, 1);
        tick();
        wr_beat(16'hA003);
        @(negedge clk);
        check("t4_end_on_4th", bus.m_req, 0);
        bus.c_we = 1'b0;
        repeat (3) tick();

        // 5: reset on beat 10 of a 32-beat video burst.
        push_grant(32'hC00404, 1'b0, 8'd31);
        bus.v_address = 32'hC00404; bus.v_burst_len = 8'd31; bus.v_req = 1'b1;
        wait_grant("t5_grant");
        bus.v_req = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) rd_beat(16'h5500 + 16'(i), DST_V);
        reset = 1'b0;
        rd_beat(16'h5509, DST_V);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_m_req", bus.m_req, 0);
        check("t5_rst_m_address", bus.m_address, 0);
        check("t5_rst_m_len", bus.m_burst_len, 0);
        tick();
        for (int i = 0; i < 3; i++) rd_beat(16'h55F0 + 16'(i), DST_NONE);
        push_grant(32'h700, 1'b0, 8'd0);
        bus.v_address = 32'h700; bus.v_burst_len = 8'd0; bus.v_req = 1'b1;
        wait_grant("t5_regrant");
        bus.v_req = 1'b0;
        tick();
        rd_beat(16'h5777, DST_V);
        repeat (3) tick();

        // 6: grant with no beats.
        push_grant(32'h900, 1'b0, 8'd0);
        bus.c_address = 32'h900; bus.c_burst_len = 8'd0; bus.c_we = 1'b0; bus.c_req = 1'b1;
        wait_grant("t6_grant");
        bus.c_req = 1'b0;
`ifdef ARB_TIMEOUT_EN
        n = 0;
        while (!bus.arb_err && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t6_arb_err_cycle", n, 255);
        check("t6_abort_mreq", bus.m_req, 0);
        @(negedge clk);
        check("t6_arb_err_pulse", bus.arb_err, 0);
        err_seen = 0;
`else
        err_seen = 0;
        n = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.arb_err) err_seen++;
            if (!bus.m_req) n++;
        end
        check("t6_no_arb_err", err_seen, 0);
        check("t6_grant_held", n, 0);
        tick();
        rd_beat(16'h6666, DST_C);
`endif
        repeat (3) tick();

        check("end_grant_q", gq.size(), 0);
        check("end_v_q", vq.size(), 0);
        check("end_c_q", cq.size(), 0);
        check("end_w_q", wq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
